wb_commit: RTL and testbench

Write-back commit stage of the MIPS32 pipeline. It consumes the registered write-back bundle (GPR write, HI/LO write, LLbit write) and owns the architectural state: the 32x32 GPR file, the HI/LO pair, the LLbit and a retired-write counter. The decode stage reads the GPR file through two read ports with same-cycle write bypass. The execute and memory stages read HI/LO and LLbit from the registered outputs.

---
 rtl/wb_commit_pkg.sv | 24 ++
 rtl/wb_commit_gpr_file.sv | 77 +++++++
 rtl/wb_commit.sv | 95 +++++++++
 tb/tb_wb_commit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// Shared definitions for the write-back commit stage: bus types, enable/reset
// encodings and the rule deciding whether a GPR write actually retires.
package wb_commit_pkg;

  localparam int WB_DATA_W  = 32;
  localparam int WB_ADDR_W  = 5;
  localparam int WB_REG_NUM = 32;
  localparam int WB_CNT_W   = 32;

  typedef logic [WB_DATA_W-1:0] reg_bus_t;
  typedef logic [WB_ADDR_W-1:0] reg_addr_bus_t;

  localparam reg_addr_bus_t NOP_REG_ADDR = '0;
  localparam reg_bus_t      ZERO_WORD    = '0;
  localparam logic          WRITE_ENABLE = 1'b1;
  localparam logic          READ_ENABLE  = 1'b1;
  localparam logic          RST_ENABLE   = 1'b0;

  // Writes aimed at $0 are architecturally dropped and do not count as retired.
  function automatic logic gpr_commit(input logic wreg, input reg_addr_bus_t wd);
    return (wreg == WRITE_ENABLE) && (wd != NOP_REG_ADDR);
  endfunction

endpackage

// File: rtl/wb_commit_gpr_file.sv
// 32-entry GPR file, one write port, two combinational read ports with same-cycle
// write bypass; $0 is hard-wired to zero. No backpressure: every write is taken.
module gpr_file
  import wb_commit_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int REG_NUM = WB_REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [DATA_W-1:0] regs_d [REG_NUM];
  logic              wr_ok;

  assign wr_ok = (we == WRITE_ENABLE) && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Priority: reset, disabled port, $0, in-flight write, stored value.
  always_comb begin
    rdata1 = '0;
    if (rst == RST_ENABLE) begin
      rdata1 = '0;
    end else if (re1 != READ_ENABLE) begin
      rdata1 = '0;
    end else if (raddr1 == '0) begin
      rdata1 = '0;
    end else if ((we == WRITE_ENABLE) && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst == RST_ENABLE) begin
      rdata2 = '0;
    end else if (re2 != READ_ENABLE) begin
      rdata2 = '0;
    end else if (raddr2 == '0) begin
      rdata2 = '0;
    end else if ((we == WRITE_ENABLE) && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_q[raddr2];
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Write-back commit: owns GPRs, HI/LO, LLbit and the retired-write counter.
// GPR reads bypass same cycle; HI/LO/LLbit/count visible next cycle; no stall, never backpressures.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int REG_NUM = WB_REG_NUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   wb_wd,
  input  logic                wb_wreg,
  input  logic [DATA_W-1:0]   wb_wdata,
  input  logic [DATA_W-1:0]   wb_hi,
  input  logic [DATA_W-1:0]   wb_lo,
  input  logic                wb_whilo,
  input  logic                wb_LLbit_we,
  input  logic                wb_LLbit_value,
  input  logic                flush,
  input  logic                re1,
  input  logic [ADDR_W-1:0]   raddr1,
  output logic [DATA_W-1:0]   rdata1,
  input  logic                re2,
  input  logic [ADDR_W-1:0]   raddr2,
  output logic [DATA_W-1:0]   rdata2,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                LLbit_o,
  output logic [WB_CNT_W-1:0] wb_cnt
);

  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                llbit_q, llbit_d;
  logic [WB_CNT_W-1:0] cnt_q, cnt_d;

  gpr_file #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_NUM (REG_NUM)
  ) u_gpr_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_wreg),
    .waddr  (wb_wd),
    .wdata  (wb_wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    llbit_d = llbit_q;
    cnt_d   = cnt_q;
    if (wb_whilo == WRITE_ENABLE) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
    // A flush kills any reservation, even one being set in the same cycle.
    if (flush) begin
      llbit_d = 1'b0;
    end else if (wb_LLbit_we == WRITE_ENABLE) begin
      llbit_d = wb_LLbit_value;
    end
    if (gpr_commit(wb_wreg, wb_wd)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      hi_q    <= '0;
      lo_q    <= '0;
      llbit_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      llbit_q <= llbit_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign LLbit_o = llbit_q;
  assign wb_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed scenarios plus a randomized run against an
// architectural model (register array, HI/LO, LLbit, retire count).
module tb_wb_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic        wb_LLbit_we;
  logic        wb_LLbit_value;
  logic        flush;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, wb_cnt;
  logic        LLbit_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo, m_cnt;
  logic        m_ll;

  always #5 clk = ~clk;

  wb_commit dut (
    .clk(clk), .rst(rst_n),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .flush(flush),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o), .wb_cnt(wb_cnt)
  );

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 0; m_lo = 0; m_ll = 0; m_cnt = 0;
  endfunction

  // Architectural read: what decode should see this cycle given the bundle in flight.
  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (!rst_n || !re || a == 5'd0) return 32'h0;
    if (wb_wreg && wb_wd == a) return wb_wdata;
    return m_gpr[a];
  endfunction

  task automatic idle();
    wb_wreg = 0; wb_wd = 0; wb_wdata = 0;
    wb_whilo = 0; wb_hi = 0; wb_lo = 0;
    wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0;
    re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
  endtask

  // Advance one edge, applying the committed bundle to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (wb_wreg && wb_wd != 0) begin
        m_gpr[wb_wd] = wb_wdata;
        m_cnt = m_cnt + 1;
      end
      if (wb_whilo) begin m_hi = wb_hi; m_lo = wb_lo; end
      if (flush) m_ll = 0;
      else if (wb_LLbit_we) m_ll = wb_LLbit_value;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hDEADBEEF;
    re1 = 1; raddr1 = 5;
    #2;
    vectors++;
    if (rdata1 !== 32'h0) begin
      miscompares++; $display("FAIL reset_bypass_blocked rdata1=%h exp=%h", rdata1, 32'h0);
    end
    tick(); tick();
    @(negedge clk);
    idle();
    rst_n = 1;
    re1 = 1; raddr1 = 5;
    #1;
    vectors++;
    if (rdata1 !== 32'h0) begin
      miscompares++; $display("FAIL reset_gpr5 rdata1=%h exp=%h", rdata1, 32'h0);
    end
    vectors++;
    if (hi_o !== 0 || lo_o !== 0 || LLbit_o !== 0 || wb_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_regs hi=%h lo=%h ll=%b cnt=%0d exp all 0", hi_o, lo_o, LLbit_o, wb_cnt);
    end
  endtask

  task automatic test_write_read();
    idle();
    wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h12345678;
    tick();
    idle();
    re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 3;
    #1;
    vectors++;
    if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678) begin
      miscompares++; $display("FAIL write_read r1=%h r2=%h exp=%h", rdata1, rdata2, 32'h12345678);
    end
    vectors++;
    if (wb_cnt !== 32'd1) begin
      miscompares++; $display("FAIL write_read_cnt cnt=%0d exp=1", wb_cnt);
    end
  endtask

  task automatic test_bypass();
    idle();
    wb_wreg = 1; wb_wd = 7; wb_wdata = 32'hA5A5A5A5;
    re2 = 1; raddr2 = 7;
    #1;
    vectors++;
    if (rdata2 !== 32'hA5A5A5A5) begin
      miscompares++; $display("FAIL bypass rdata2=%h exp=%h", rdata2, 32'hA5A5A5A5);
    end
    re2 = 0;
    #1;
    vectors++;
    if (rdata2 !== 32'h0) begin
      miscompares++; $display("FAIL bypass_re0 rdata2=%h exp=0", rdata2);
    end
    tick();
    idle();
    re2 = 1; raddr2 = 7;
    #1;
    vectors++;
    if (rdata2 !== 32'hA5A5A5A5) begin
      miscompares++; $display("FAIL bypass_stored rdata2=%h exp=%h", rdata2, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] cnt_before;
    idle();
    cnt_before = m_cnt;
    wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFFFFFF;
    re1 = 1; raddr1 = 0;
    #1;
    vectors++;
    if (rdata1 !== 32'h0) begin
      miscompares++; $display("FAIL zero_write_cycle rdata1=%h exp=0", rdata1);
    end
    tick();
    idle();
    re1 = 1; raddr1 = 0;
    #1;
    vectors++;
    if (rdata1 !== 32'h0) begin
      miscompares++; $display("FAIL zero_after rdata1=%h exp=0", rdata1);
    end
    vectors++;
    if (wb_cnt !== cnt_before) begin
      miscompares++; $display("FAIL zero_cnt cnt=%0d exp=%0d", wb_cnt, cnt_before);
    end
  endtask

  task automatic test_hilo_llbit();
    idle();
    wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
    tick();
    idle();
    vectors++;
    if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
      miscompares++; $display("FAIL hilo hi=%h lo=%h exp=1/2", hi_o, lo_o);
    end
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    tick();
    vectors++;
    if (LLbit_o !== 1'b1) begin
      miscompares++; $display("FAIL llbit_set ll=%b exp=1", LLbit_o);
    end
    flush = 1;
    tick();
    idle();
    vectors++;
    if (LLbit_o !== 1'b0) begin
      miscompares++; $display("FAIL llbit_flush_wins ll=%b exp=0", LLbit_o);
    end
  endtask

  task automatic test_async_reset();
    idle();
    wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h12345678;
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    wb_whilo = 1; wb_hi = 32'h55; wb_lo = 32'h66;
    tick();
    idle();
    re1 = 1; raddr1 = 3;
    #1;
    vectors++;
    if (rdata1 !== 32'h12345678 || LLbit_o !== 1'b1) begin
      miscompares++; $display("FAIL async_pre r1=%h ll=%b exp=12345678/1", rdata1, LLbit_o);
    end
    #1;
    rst_n = 0;
    model_reset();
    #1;
    vectors++;
    if (rdata1 !== 0 || hi_o !== 0 || lo_o !== 0 || LLbit_o !== 0 || wb_cnt !== 0) begin
      miscompares++;
      $display("FAIL async_reset r1=%h hi=%h lo=%h ll=%b cnt=%0d exp all 0", rdata1, hi_o, lo_o, LLbit_o, wb_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    vectors++;
    if (rdata1 !== 32'h0) begin
      miscompares++; $display("FAIL async_released r1=%h exp=0", rdata1);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      wb_wreg = ($urandom_range(0, 3) != 0);
      wb_wd = 5'($urandom_range(0, 31));
      wb_wdata = $urandom;
      wb_whilo = $urandom_range(0, 1);
      wb_hi = $urandom; wb_lo = $urandom;
      wb_LLbit_we = $urandom_range(0, 1);
      wb_LLbit_value = $urandom_range(0, 1);
      flush = ($urandom_range(0, 7) == 0);
      re1 = ($urandom_range(0, 7) != 0);
      re2 = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      #1;
      e1 = exp_rd(re1, raddr1);
      e2 = exp_rd(re2, raddr2);
      vectors++;
      if (rdata1 !== e1 || rdata2 !== e2) begin
        miscompares++;
        $display("FAIL rand_read n=%0d a1=%0d r1=%h exp=%h a2=%0d r2=%h exp=%h", n, raddr1, rdata1, e1, raddr2, rdata2, e2);
      end
      tick();
      vectors++;
      if (hi_o !== m_hi || lo_o !== m_lo || LLbit_o !== m_ll || wb_cnt !== m_cnt) begin
        miscompares++;
        $display("FAIL rand_state n=%0d hi=%h/%h lo=%h/%h ll=%b/%b cnt=%0d/%0d", n, hi_o, m_hi, lo_o, m_lo, LLbit_o, m_ll, wb_cnt, m_cnt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_hilo_llbit();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
